// File: rtl/v_fsm.sv
// v_fsm: vertical timing FSM for 640x480@60 VGA; define V_FRAME_CNT_EN to add the 8-bit frame counter output
module v_fsm #(
    parameter int   V_DISP  = 480,
    parameter int   V_FRONT = 10,
    parameter int   V_SYNC  = 2,
    parameter int   V_BACK  = 33,
    parameter logic VS_POL  = 1'b0,
    parameter int   CNT_W   = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             str_i,
    input  logic             h_end_i,
    output logic             busy_o,
    output logic             vs_o,
    output logic             v_dsp_o,
    output logic [CNT_W-1:0] v_cnt_o,
`ifdef V_FRAME_CNT_EN
    output logic             frame_o,
    output logic [7:0]       frame_cnt_o
`else
    output logic             frame_o
`endif
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] DISP  = 3'd1;
    localparam logic [2:0] FRONT = 3'd2;
    localparam logic [2:0] SYNC  = 3'd3;
    localparam logic [2:0] BACK  = 3'd4;

    localparam logic [CNT_W-1:0] L_FRONT = CNT_W'(V_DISP);
    localparam logic [CNT_W-1:0] L_SYNC  = CNT_W'(V_DISP + V_FRONT);
    localparam logic [CNT_W-1:0] L_BACK  = CNT_W'(V_DISP + V_FRONT + V_SYNC);
    localparam logic [CNT_W-1:0] L_LAST  = CNT_W'(V_DISP + V_FRONT + V_SYNC + V_BACK - 1);

    logic [2:0]       state;
    logic [2:0]       nxt_state;
    logic [CNT_W-1:0] nxt_cnt;
    logic             wrap;

    function automatic logic [2:0] state_of(input logic [CNT_W-1:0] c);
        return (c < L_FRONT) ? DISP : (c < L_SYNC) ? FRONT : (c < L_BACK) ? SYNC : BACK;
    endfunction

    // Next line/state: only h_end_i advances a running frame; stop is taken only at wrap
    always_comb begin
        nxt_state = state;
        nxt_cnt   = v_cnt_o;
        wrap      = 1'b0;
        case (state)
            IDLE: begin
                nxt_cnt   = '0;
                nxt_state = str_i ? DISP : IDLE;
            end
            DISP, FRONT, SYNC, BACK: begin
                if (h_end_i) begin
                    wrap      = (v_cnt_o >= L_LAST);
                    nxt_cnt   = wrap ? '0 : v_cnt_o + 1'b1;
                    nxt_state = wrap ? (str_i ? DISP : IDLE) : state_of(nxt_cnt);
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = '0;
            end
        endcase
    end

    // State, line counter and all outputs registered from the next-state decode
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            v_cnt_o <= '0;
            busy_o  <= 1'b0;
            vs_o    <= ~VS_POL;
            v_dsp_o <= 1'b0;
            frame_o <= 1'b0;
        end else begin
            state   <= nxt_state;
            v_cnt_o <= nxt_cnt;
            busy_o  <= (nxt_state != IDLE);
            vs_o    <= (nxt_state == SYNC) ? VS_POL : ~VS_POL;
            v_dsp_o <= (nxt_state == DISP);
            frame_o <= wrap;
        end
    end

`ifdef V_FRAME_CNT_EN
    // Frame counter steps on each wrap, rolling over naturally at 8 bits
    always_ff @(posedge clk_i) begin
        if (rst_i) frame_cnt_o <= 8'd0;
        else if (wrap) frame_cnt_o <= frame_cnt_o + 8'd1;
    end
`else
`endif
endmodule
